ibex_efpga_if: RTL and testbench



---
 rtl/ibex_efpga_if.sv | 149 ++++++++++++++
 tb/tb_ibex_efpga_if.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_efpga_if.sv
// Launch/wait/hold sequencer between the execute stage and the eFPGA fabric.
// Optional watchdog in WAIT is compiled in with `define IBEX_EFPGA_TIMEOUT_EN.
module ibex_efpga_if #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   output logic        ready_o,
   input  logic [1:0]  operator_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic [3:0]  delay_i,
   input  logic        flush_i,
   output logic        fab_en_o,
   output logic [1:0]  fab_op_o,
   output logic [31:0] fab_a_o,
   output logic [31:0] fab_b_o,
   input  logic [31:0] fab_res_a_i,
   input  logic [31:0] fab_res_b_i,
   input  logic [31:0] fab_res_c_i,
   input  logic        fab_done_i,
   output logic        valid_o,
   input  logic        ack_i,
   output logic [31:0] result_a_o,
   output logic [31:0] result_b_o,
   output logic [31:0] result_c_o,
   output logic        err_o,
   output logic [1:0]  dbg_state_o
);

   // Handshake: req_i is taken only in a cycle with ready_o=1; results are
   // offered with valid_o=1 and retired by ack_i; flush_i overrides both.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t      r_state, w_next;
   logic [1:0]  r_op;
   logic [31:0] r_a, r_b;
   logic [3:0]  r_delay, r_cnt;
   logic [31:0] r_res_a, r_res_b, r_res_c;
   logic        w_accept, w_done_hit, w_timeout;

   assign w_accept   = (r_state == S_IDLE) && req_i && !flush_i;
   assign w_done_hit = (r_state == S_WAIT) &&
                       ((r_delay == 4'd0) ? fab_done_i : (r_cnt == 4'd1));

`ifdef IBEX_EFPGA_TIMEOUT_EN
   localparam logic [7:0] LP_WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_wdog;
   logic       r_err;

   // A real completion in the last allowed WAIT cycle still wins over expiry.
   assign w_timeout = (r_state == S_WAIT) && !w_done_hit && (r_wdog == LP_WDOG_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= 8'd0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == S_LAUNCH)    r_wdog <= 8'd0;
         else if (r_state == S_WAIT) r_wdog <= r_wdog + 8'd1;
         if (flush_i)                         r_err <= 1'b0;
         else if (w_timeout)                  r_err <= 1'b1;
         else if (r_state == S_HOLD && ack_i) r_err <= 1'b0;
      end
   end

   assign err_o = r_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_timeout        = 1'b0;
   assign err_o            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush_i) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (req_i) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (w_done_hit || w_timeout) w_next = S_HOLD;
            S_HOLD:   if (ack_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // A flush arriving in LAUNCH suppresses the strobe so the fabric never starts.
   always_comb begin
      ready_o  = (r_state == S_IDLE);
      valid_o  = (r_state == S_HOLD);
      fab_en_o = (r_state == S_LAUNCH) && !flush_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= 2'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_delay <= 4'd0;
         r_cnt   <= 4'd0;
         r_res_a <= 32'd0;
         r_res_b <= 32'd0;
         r_res_c <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op    <= operator_i;
            r_a     <= operand_a_i;
            r_b     <= operand_b_i;
            r_delay <= delay_i;
         end
         if (r_state == S_LAUNCH && !flush_i)
            r_cnt <= r_delay;
         else if (r_state == S_WAIT && !flush_i && r_delay != 4'd0 && r_cnt != 4'd1)
            r_cnt <= r_cnt - 4'd1;
         if (!flush_i && w_done_hit) begin
            r_res_a <= fab_res_a_i;
            r_res_b <= fab_res_b_i;
            r_res_c <= fab_res_c_i;
         end else if (!flush_i && w_timeout) begin
            r_res_a <= 32'd0;
            r_res_b <= 32'd0;
            r_res_c <= 32'd0;
         end
      end
   end

   assign fab_op_o    = r_op;
   assign fab_a_o     = r_a;
   assign fab_b_o     = r_b;
   assign result_a_o  = r_res_a;
   assign result_b_o  = r_res_b;
   assign result_c_o  = r_res_c;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ibex_efpga_if.sv
// Randomized bench for ibex_efpga_if; expected timing and captured words are
// derived from cycle arithmetic on the request (accept at 0, capture at D+1).
module tb_ibex_efpga_if;

`ifdef IBEX_EFPGA_TIMEOUT_EN
   localparam int TO    = 8;
   localparam int MAX_D = 7;
`else
   localparam int TO    = 255;
   localparam int MAX_D = 15;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, ready_o, flush_i, fab_en_o, fab_done_i, valid_o, ack_i, err_o;
   logic [1:0]  operator_i, fab_op_o, dbg_state;
   logic [31:0] operand_a_i, operand_b_i, fab_a_o, fab_b_o;
   logic [31:0] fab_res_a_i, fab_res_b_i, fab_res_c_i;
   logic [31:0] result_a_o, result_b_o, result_c_o;
   logic [3:0]  delay_i;

   int n_vec = 0;
   int n_err = 0;

   logic [1:0]  last_op;
   logic [31:0] last_a, last_b;
   logic [95:0] last_res;
   logic [95:0] exp_q[$];

   ibex_efpga_if #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .ready_o(ready_o),
      .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .delay_i(delay_i), .flush_i(flush_i), .fab_en_o(fab_en_o), .fab_op_o(fab_op_o),
      .fab_a_o(fab_a_o), .fab_b_o(fab_b_o), .fab_res_a_i(fab_res_a_i),
      .fab_res_b_i(fab_res_b_i), .fab_res_c_i(fab_res_c_i), .fab_done_i(fab_done_i),
      .valid_o(valid_o), .ack_i(ack_i), .result_a_o(result_a_o),
      .result_b_o(result_b_o), .result_c_o(result_c_o), .err_o(err_o),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [95:0] exp);
      chk({tag, "_res_a"}, result_a_o, exp[95:64]);
      chk({tag, "_res_b"}, result_b_o, exp[63:32]);
      chk({tag, "_res_c"}, result_c_o, exp[31:0]);
   endtask

   task automatic drive_noise();
      fab_res_a_i = $urandom;
      fab_res_b_i = $urandom;
      fab_res_c_i = $urandom;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      operator_i  = 2'($urandom_range(0, 3));
      delay_i     = 4'($urandom_range(0, 15));
      req_i       = 1'($urandom_range(0, 1));
   endtask

   // Idle cycle in which a request is presented (dropped when fl=1).
   task automatic cycle0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input logic fl);
      @(negedge clk);
      drive_noise();
      req_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b; delay_i = d;
      flush_i = fl; ack_i = 1'($urandom_range(0, 1)); fab_done_i = 1'($urandom_range(0, 1));
      #1;
      chk("idle_ready", ready_o, 1);
      chk("idle_valid", valid_o, 0);
      chk("idle_fab_en", fab_en_o, 0);
      chk("idle_err", err_o, 0);
      chk("idle_fab_op", fab_op_o, last_op);
      chk("idle_fab_a", fab_a_o, last_a);
      chk("idle_fab_b", fab_b_o, last_b);
      chk_res("idle", last_res);
      if (!fl) begin
         last_op = op; last_a = a; last_b = b;
      end
   endtask

   task automatic cycle1();
      @(negedge clk);
      drive_noise();
      flush_i = 1'b0; ack_i = 1'($urandom_range(0, 1)); fab_done_i = 1'($urandom_range(0, 1));
      #1;
      chk("launch_en", fab_en_o, 1);
      chk("launch_ready", ready_o, 0);
      chk("launch_valid", valid_o, 0);
      chk("launch_fab_op", fab_op_o, last_op);
      chk("launch_fab_a", fab_a_o, last_a);
      chk("launch_fab_b", fab_b_o, last_b);
   endtask

   task automatic run_op(input logic [3:0] d, input int done_at, input int hold);
      int cap;
      cycle0(2'($urandom_range(0, 3)), $urandom, $urandom, d, 1'b0);
      cycle1();
      cap = (d != 0) ? int'(d) + 1 : done_at;
      for (int c = 2; c <= cap; c++) begin
         @(negedge clk);
         drive_noise();
         ack_i = 1'($urandom_range(0, 1));
         fab_done_i = (d == 0) ? (c == done_at) : 1'($urandom_range(0, 1));
         #1;
         chk("wait_en", fab_en_o, 0);
         chk("wait_valid", valid_o, 0);
         chk("wait_ready", ready_o, 0);
         if (c == cap) exp_q.push_back({fab_res_a_i, fab_res_b_i, fab_res_c_i});
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         drive_noise();
         ack_i = (h == hold); fab_done_i = 1'($urandom_range(0, 1));
         #1;
         if (h == 0) last_res = exp_q.pop_front();
         chk("hold_valid", valid_o, 1);
         chk("hold_ready", ready_o, 0);
         chk("hold_en", fab_en_o, 0);
         chk("hold_err", err_o, 0);
         chk("hold_fab_a", fab_a_o, last_a);
         chk_res("hold", last_res);
      end
   endtask

   task automatic flush_op(input logic [3:0] d, input int f);
      logic [95:0] cap_v;
      cap_v = '0;
      cycle0(2'($urandom_range(0, 3)), $urandom, $urandom, d, f == 0);
      for (int c = 1; c <= f; c++) begin
         @(negedge clk);
         drive_noise();
         flush_i = (c == f); ack_i = 1'b0; fab_done_i = 1'($urandom_range(0, 1));
         #1;
         chk("fl_en", fab_en_o, (c == 1 && c != f));
         chk("fl_valid", valid_o, (c >= int'(d) + 2));
         if (c == int'(d) + 1) cap_v = {fab_res_a_i, fab_res_b_i, fab_res_c_i};
         if (c >= int'(d) + 2) chk_res("fl_hold", cap_v);
      end
      if (f >= int'(d) + 2) last_res = cap_v;
   endtask

   task automatic reset_op(input logic [3:0] d, input int k);
      cycle0(2'($urandom_range(0, 3)), $urandom, $urandom, d, 1'b0);
      for (int c = 1; c <= k; c++) begin
         @(negedge clk);
         drive_noise();
         flush_i = 1'b0; ack_i = 1'b0; fab_done_i = 1'b1;
         rst = (c == k);
      end
      @(negedge clk);
      rst = 1'b0; req_i = 1'b0;
      #1;
      chk("rst_ready", ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_en", fab_en_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_fab_op", fab_op_o, 0);
      chk("rst_fab_a", fab_a_o, 0);
      chk("rst_fab_b", fab_b_o, 0);
      chk_res("rst", '0);
      last_op = '0; last_a = '0; last_b = '0; last_res = '0;
   endtask

   task automatic stall_op();
      cycle0(2'd1, $urandom, $urandom, 4'd0, 1'b0);
      cycle1();
`ifdef IBEX_EFPGA_TIMEOUT_EN
      for (int c = 2; c <= TO + 2; c++) begin
         @(negedge clk);
         drive_noise();
         fab_done_i = 1'b0; ack_i = (c == TO + 2);
         #1;
         chk("wd_valid", valid_o, (c == TO + 2));
         chk("wd_err", err_o, (c == TO + 2));
      end
      chk_res("wd", '0);
      last_res = '0;
`else
      for (int c = 2; c < 302; c++) begin
         @(negedge clk);
         drive_noise();
         fab_done_i = 1'b0; ack_i = 1'($urandom_range(0, 1));
         #1;
         if (c % 50 == 0) chk("stall_valid", valid_o, 0);
      end
      chk("stall_ready", ready_o, 0);
      chk("stall_err", err_o, 0);
      @(negedge clk);
      flush_i = 1'b1; req_i = 1'b0;
      #1;
      chk("stall_flush_en", fab_en_o, 0);
`endif
   endtask

   initial begin
      rst = 1'b1; req_i = 0; flush_i = 0; ack_i = 0; fab_done_i = 0;
      operator_i = 0; operand_a_i = 0; operand_b_i = 0; delay_i = 0;
      fab_res_a_i = 0; fab_res_b_i = 0; fab_res_c_i = 0;
      last_op = '0; last_a = '0; last_b = '0; last_res = '0;
      @(negedge clk); @(negedge clk);
      #1;
      chk("por_ready", ready_o, 1);
      chk("por_valid", valid_o, 0);
      chk("por_en", fab_en_o, 0);
      chk("por_err", err_o, 0);
      chk("por_fab_op", fab_op_o, 0);
      chk("por_fab_a", fab_a_o, 0);
      chk("por_fab_b", fab_b_o, 0);
      chk_res("por", '0);
      rst = 1'b0;

      run_op(4'd3, 0, 1);
      run_op(4'd1, 0, 0);
      run_op(4'd0, 6, 1);
      run_op(4'd0, 2, 0);
      run_op(4'd2, 0, 10);
      flush_op(4'd5, 2);
      flush_op(4'd2, 0);
      flush_op(4'd2, 1);
      run_op(4'(MAX_D), 0, 0);
      reset_op(4'd4, 3);
      stall_op();

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: run_op(4'($urandom_range(1, MAX_D)), 0, $urandom_range(0, 4));
            4, 5, 6:    run_op(4'd0, $urandom_range(2, 8), $urandom_range(0, 4));
            7, 8: begin
               int d;
               d = $urandom_range(1, MAX_D);
               flush_op(4'(d), $urandom_range(0, d + 4));
            end
            default:    reset_op(4'($urandom_range(1, MAX_D)), $urandom_range(1, 4));
         endcase
      end

      @(negedge clk);
      req_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
      #1;
      chk("end_ready", ready_o, 1);
      chk("end_valid", valid_o, 0);
      chk_res("end", last_res);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
